// File: rtl/line_window_gen_pkg.sv
// Shared definitions for the 3x3 line-window generator: FSM encoding,
// window geometry and the row-major packed-window index convention.
package line_window_gen_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_FILL   = 2'd1,
        ST_STREAM = 2'd2,
        ST_DONE   = 2'd3
    } state_e;

    localparam int WIN_DIM  = 3;
    localparam int WIN_TAPS = WIN_DIM * WIN_DIM;

    // Tap k of window_out sits at row k/3, column k%3 (k=0 top-left, k=8 bottom-right).
    function automatic int win_idx(input int row, input int col);
        return row * WIN_DIM + col;
    endfunction

endpackage

// File: rtl/line_window_gen_line_buffer_ram.sv
// One image line of pixel storage: single port, combinational read of the
// addressed entry, write committed at the clock edge (read-before-write).
module line_buffer_ram #(
    parameter int DATA_WIDTH = 8,
    parameter int DEPTH      = 32,
    parameter int ADDR_WIDTH = 5
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  we,
    input  logic [DATA_WIDTH-1:0] wdata,
    output logic [DATA_WIDTH-1:0] rdata
);

    logic [DATA_WIDTH-1:0] mem_r [0:DEPTH-1];

    // Contents are never read before being written within a frame, so no reset.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_r[addr] <= wdata;
        end
    end

    assign rdata = mem_r[addr];

endmodule

// File: rtl/line_window_gen.sv
// 3x3 sliding-window generator for raster-scan pixel streams. Two line
// buffers plus a 3x3 shift register produce one window per in-image pixel.
module line_window_gen
    import line_window_gen_pkg::*;
#(
    parameter int DATA_WIDTH = 8,
    parameter int IMG_WIDTH  = 32,
    parameter int IMG_HEIGHT = 32
) (
    input  logic                             clk,
    input  logic                             reset_n,
    input  logic                             start,
    input  logic [DATA_WIDTH-1:0]            pixel_in,
    input  logic                             pixel_in_valid,
    output logic [WIN_TAPS*DATA_WIDTH-1:0]   window_out,
    output logic                             window_valid,
    output logic                             busy,
    output logic                             frame_done
);

    localparam int COL_W = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
    localparam int ROW_W = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;

    localparam logic [COL_W-1:0] COL_ZERO = COL_W'(0);
    localparam logic [COL_W-1:0] COL_ONE  = COL_W'(1);
    localparam logic [COL_W-1:0] COL_TWO  = COL_W'(2);
    localparam logic [COL_W-1:0] COL_LAST = COL_W'(IMG_WIDTH - 1);
    localparam logic [ROW_W-1:0] ROW_ZERO = ROW_W'(0);
    localparam logic [ROW_W-1:0] ROW_ONE  = ROW_W'(1);
    localparam logic [ROW_W-1:0] ROW_TWO  = ROW_W'(2);
    localparam logic [ROW_W-1:0] ROW_LAST = ROW_W'(IMG_HEIGHT - 1);

    state_e                 state_r;
    logic [COL_W-1:0]       col_r;
    logic [ROW_W-1:0]       row_r;
    logic [DATA_WIDTH-1:0]  win_r [0:WIN_TAPS-1];
    logic                   window_valid_r;
    logic                   busy_r;
    logic                   frame_done_r;

    logic                   accept_s;
    logic                   in_window_s;
    logic                   col_last_s;
    logic                   frame_end_s;
    logic                   fill_end_s;
    logic [DATA_WIDTH-1:0]  lb0_rd_s;
    logic [DATA_WIDTH-1:0]  lb1_rd_s;

    // lb0 holds the previous line, lb1 the one before; lb1 is refilled from lb0's old entry.
    line_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (COL_W)
    ) u_lb0 (
        .clk   (clk),
        .addr  (col_r),
        .we    (accept_s),
        .wdata (pixel_in),
        .rdata (lb0_rd_s)
    );

    line_buffer_ram #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (IMG_WIDTH),
        .ADDR_WIDTH (COL_W)
    ) u_lb1 (
        .clk   (clk),
        .addr  (col_r),
        .we    (accept_s),
        .wdata (lb0_rd_s),
        .rdata (lb1_rd_s)
    );

    // Accept qualification and raster-position decodes from pre-increment counters.
    always_comb begin
        accept_s    = 1'b0;
        in_window_s = (row_r >= ROW_TWO) && (col_r >= COL_TWO);
        col_last_s  = (col_r == COL_LAST);
        frame_end_s = (col_r == COL_LAST) && (row_r == ROW_LAST);
        fill_end_s  = (col_r == COL_ONE) && (row_r == ROW_TWO);
        if ((state_r == ST_FILL) || (state_r == ST_STREAM)) begin
            accept_s = pixel_in_valid;
        end else begin
            accept_s = 1'b0;
        end
    end

    // Frame FSM, raster counters and registered status outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_IDLE;
            col_r          <= COL_ZERO;
            row_r          <= ROW_ZERO;
            window_valid_r <= 1'b0;
            busy_r         <= 1'b0;
            frame_done_r   <= 1'b0;
        end else begin
            window_valid_r <= accept_s && in_window_s;
            frame_done_r   <= 1'b0;

            if (accept_s) begin
                if (col_last_s) begin
                    col_r <= COL_ZERO;
                    row_r <= frame_end_s ? ROW_ZERO : (row_r + ROW_ONE);
                end else begin
                    col_r <= col_r + COL_ONE;
                end
            end

            case (state_r)
                ST_IDLE: begin
                    if (start) begin
                        state_r <= ST_FILL;
                        col_r   <= COL_ZERO;
                        row_r   <= ROW_ZERO;
                        busy_r  <= 1'b1;
                    end
                end
                ST_FILL: begin
                    if (accept_s && fill_end_s) begin
                        state_r <= ST_STREAM;
                    end
                end
                ST_STREAM: begin
                    if (accept_s && frame_end_s) begin
                        state_r <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    // busy stays up through DONE so it falls together with frame_done rising
                    state_r      <= ST_IDLE;
                    frame_done_r <= 1'b1;
                    busy_r       <= 1'b0;
                end
                default: begin
                    state_r <= ST_IDLE;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    // 3x3 window shift register: shift left on accept, new right column from buffers and input.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int k = 0; k < WIN_TAPS; k++) begin
                win_r[k] <= {DATA_WIDTH{1'b0}};
            end
        end else if (accept_s) begin
            for (int j = 0; j < WIN_DIM; j++) begin
                win_r[win_idx(j, 0)] <= win_r[win_idx(j, 1)];
                win_r[win_idx(j, 1)] <= win_r[win_idx(j, 2)];
            end
            win_r[win_idx(0, 2)] <= lb1_rd_s;
            win_r[win_idx(1, 2)] <= lb0_rd_s;
            win_r[win_idx(2, 2)] <= pixel_in;
        end
    end

    // Flatten the tap array into the packed row-major window port.
    always_comb begin
        window_out = {(WIN_TAPS*DATA_WIDTH){1'b0}};
        for (int k = 0; k < WIN_TAPS; k++) begin
            window_out[k*DATA_WIDTH +: DATA_WIDTH] = win_r[k];
        end
    end

    assign window_valid = window_valid_r;
    assign busy         = busy_r;
    assign frame_done   = frame_done_r;

endmodule
